// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed active-low seven-segment bus; decodes stable digit patterns back to BCD.
// Optional macro SEG_SCAN_DP_EN: include seg[7] (decimal point) in the stability compare and capture it per digit.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digit_bcd,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     dp,
  output logic                  update,
  output logic [2:0]            update_idx,
  output logic                  err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURED = 2'd2;

`ifdef SEG_SCAN_DP_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

  logic [7:0]        seg_q, seg_p;
  logic [DIGITS-1:0] an_q, an_p;
  logic [1:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              capture;
  logic              selectable;
  logic              same_as_prev;
  logic [3:0]        zero_cnt;
  logic [2:0]        sel_idx;
  logic [3:0]        dec_val;
  logic              dec_hit;
  logic              dec_blank;
  logic              do_write;

  // Sample S and the previous sample P; both reset to all ones (nothing selected).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
      an_q  <= '1;
      seg_p <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= seg;
      an_q  <= an;
      seg_p <= seg_q;
      an_p  <= an_q;
    end
  end

  assign same_as_prev = (an_q == an_p) && ((seg_q & CMP_MASK) == (seg_p & CMP_MASK));

  always_comb begin
    zero_cnt = '0;
    sel_idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        sel_idx  = 3'(i);
      end
    end
  end

  assign selectable = (zero_cnt == 4'd1);

  // Capture fires whenever the count would reach the window length, so a window of 1 captures on entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (selectable) begin
          state_n = ST_SETTLE;
          cnt_n   = CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (!selectable) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (same_as_prev) begin
          if (cnt != CNT_MAX) cnt_n = cnt + CNT_ONE;
        end else begin
          cnt_n = CNT_ONE;
        end
      end
      ST_CAPTURED: begin
        if (!selectable) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (!same_as_prev) begin
          state_n = ST_SETTLE;
          cnt_n   = CNT_ONE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (state_n == ST_SETTLE && cnt_n == CNT_MAX) begin
      capture = 1'b1;
      state_n = ST_CAPTURED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    dec_val   = 4'hF;
    dec_hit   = 1'b1;
    dec_blank = 1'b0;
    case (seg_q[6:0])
      7'h40: dec_val = 4'd0;
      7'h79: dec_val = 4'd1;
      7'h24: dec_val = 4'd2;
      7'h30: dec_val = 4'd3;
      7'h19: dec_val = 4'd4;
      7'h12: dec_val = 4'd5;
      7'h02: dec_val = 4'd6;
      7'h78: dec_val = 4'd7;
      7'h00: dec_val = 4'd8;
      7'h10: dec_val = 4'd9;
      7'h7F: begin
        dec_hit   = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_hit = 1'b0;
    endcase
  end

  assign do_write = capture && (dec_hit || dec_blank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_bcd   <= '1;
      digit_valid <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      err         <= 1'b0;
    end else begin
      update <= do_write;
      err    <= capture && !(dec_hit || dec_blank);
      if (do_write) update_idx <= sel_idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (do_write && sel_idx == 3'(i)) begin
          digit_bcd[4*i +: 4] <= dec_val;
          digit_valid[i]      <= dec_hit;
        end
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [DIGITS-1:0] dp_q;

  // Segment lines are active-low, so a low dp line means the point is lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (do_write && sel_idx == 3'(i)) dp_q[i] <= ~seg_q[7];
      end
    end
  end

  assign dp = dp_q;
`else
  assign dp = '0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] digit_bcd;
  logic [3:0]  digit_valid;
  logic [3:0]  dp;
  logic        update;
  logic [2:0]  update_idx;
  logic        err;

  int n_checks;
  int n_fail;
  int upd_cnt;
  int err_cnt;
  int both_cnt;
  int tick_no;
  int last_upd_tick;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

`ifdef SEG_SCAN_DP_EN
  localparam logic [3:0] EXP_DP_FINAL = 4'b1000;
`else
  localparam logic [3:0] EXP_DP_FINAL = 4'b0000;
`endif

  seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .digit_bcd   (digit_bcd),
    .digit_valid (digit_valid),
    .dp          (dp),
    .update      (update),
    .update_idx  (update_idx),
    .err         (err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counts();
    upd_cnt       = 0;
    err_cnt       = 0;
    both_cnt      = 0;
    tick_no       = 0;
    last_upd_tick = -1;
    got_q.delete();
  endtask

  // Advance one edge and record any pulses seen just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (update) begin
      upd_cnt++;
      last_upd_tick = tick_no;
      got_q.push_back(update_idx);
    end
    if (err) err_cnt++;
    if (update && err) both_cnt++;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int cycles);
    an  = a;
    seg = s;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seg   = 8'hFF;
    an    = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (digit_bcd !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bcd: got %h expected ffff", digit_bcd); end
    n_checks++;
    if (digit_valid !== 4'h0 || dp !== 4'h0) begin n_fail++; $display("FAIL reset_valid_dp: got %b %b expected 0000 0000", digit_valid, dp); end
    n_checks++;
    if (update !== 1'b0 || err !== 1'b0 || update_idx !== 3'd0) begin
      n_fail++; $display("FAIL reset_pulses: got upd=%b err=%b idx=%0d expected 0 0 0", update, err, update_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_capture();
    clear_counts();
    drive(4'b1110, 8'hC0, 10);
    n_checks++;
    if (upd_cnt !== 1) begin n_fail++; $display("FAIL first_upd_count: got %0d expected 1", upd_cnt); end
    n_checks++;
    if (last_upd_tick !== 5) begin n_fail++; $display("FAIL first_latency: got tick %0d expected 5 (edge 4)", last_upd_tick); end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 3'd0) begin n_fail++; $display("FAIL first_idx: got %0d entries expected one idx 0", got_q.size()); end
    n_checks++;
    if (digit_bcd[3:0] !== 4'd0 || digit_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL first_value: got %h valid %b expected 0 valid 1", digit_bcd[3:0], digit_valid[0]);
    end
  endtask

  task automatic test_scan();
    logic [2:0] e;
    logic [2:0] g;
    clear_counts();
    exp_q.delete();
    for (int d = 0; d < 4; d++) exp_q.push_back(3'(d));
    drive(4'b1110, 8'hA4, 6);
    drive(4'b1101, 8'h99, 6);
    drive(4'b1011, 8'h82, 6);
    drive(4'b0111, 8'h90, 6);
    n_checks++;
    if (digit_bcd !== 16'h9642) begin n_fail++; $display("FAIL scan_bcd: got %h expected 9642", digit_bcd); end
    n_checks++;
    if (digit_valid !== 4'hF) begin n_fail++; $display("FAIL scan_valid: got %b expected 1111", digit_valid); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL scan_upd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL scan_idx: got %0d expected %0d", g, e); end
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    drive(4'b1011, 8'hB0, 3);
    drive(4'b1011, 8'h80, 5);
    n_checks++;
    if (upd_cnt !== 1) begin n_fail++; $display("FAIL glitch_upd_count: got %0d expected 1", upd_cnt); end
    n_checks++;
    if (last_upd_tick !== 8) begin n_fail++; $display("FAIL glitch_latency: got tick %0d expected 8", last_upd_tick); end
    n_checks++;
    if (digit_bcd[11:8] !== 4'd8) begin n_fail++; $display("FAIL glitch_value: got %h expected 8", digit_bcd[11:8]); end
  endtask

  task automatic test_err_blank();
    clear_counts();
    drive(4'b1101, 8'h8C, 6);
    n_checks++;
    if (err_cnt !== 1 || upd_cnt !== 0) begin n_fail++; $display("FAIL err_pulse: got err=%0d upd=%0d expected 1 0", err_cnt, upd_cnt); end
    n_checks++;
    if (digit_bcd[7:4] !== 4'd4 || digit_valid[1] !== 1'b1) begin
      n_fail++; $display("FAIL err_unchanged: got %h valid %b expected 4 valid 1", digit_bcd[7:4], digit_valid[1]);
    end
    clear_counts();
    drive(4'b1101, 8'hFF, 6);
    n_checks++;
    if (upd_cnt !== 1 || err_cnt !== 0 || got_q.size() != 1 || got_q[0] !== 3'd1) begin
      n_fail++; $display("FAIL blank_upd: got upd=%0d err=%0d expected 1 0 idx 1", upd_cnt, err_cnt);
    end
    n_checks++;
    if (digit_bcd[7:4] !== 4'hF || digit_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL blank_value: got %h valid %b expected f valid 0", digit_bcd[7:4], digit_valid[1]);
    end
  endtask

  task automatic test_unselectable_and_reset();
    clear_counts();
    drive(4'b1100, 8'hC0, 8);
    drive(4'b1111, 8'hC0, 8);
    n_checks++;
    if (upd_cnt !== 0 || err_cnt !== 0) begin n_fail++; $display("FAIL unsel_pulses: got upd=%0d err=%0d expected 0 0", upd_cnt, err_cnt); end
    drive(4'b1110, 8'hF9, 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (digit_bcd !== 16'hFFFF || digit_valid !== 4'h0 || dp !== 4'h0) begin
      n_fail++; $display("FAIL midreset_regs: got %h %b %b expected ffff 0000 0000", digit_bcd, digit_valid, dp);
    end
    n_checks++;
    if (update !== 1'b0 || err !== 1'b0 || update_idx !== 3'd0) begin
      n_fail++; $display("FAIL midreset_pulses: got upd=%b err=%b idx=%0d expected 0 0 0", update, err, update_idx);
    end
    rst_n = 1'b1;
    clear_counts();
    drive(4'b1110, 8'hF9, 8);
    n_checks++;
    if (upd_cnt !== 1 || last_upd_tick !== 5) begin
      n_fail++; $display("FAIL postreset_capture: got %0d updates at tick %0d expected 1 at 5", upd_cnt, last_upd_tick);
    end
    n_checks++;
    if (digit_bcd[3:0] !== 4'd1) begin n_fail++; $display("FAIL postreset_value: got %h expected 1", digit_bcd[3:0]); end
  endtask

  task automatic test_dp();
    clear_counts();
    drive(4'b0111, 8'h40, 6);
    n_checks++;
    if (upd_cnt !== 1 || got_q.size() != 1 || got_q[0] !== 3'd3) begin
      n_fail++; $display("FAIL dp_upd: got %0d updates expected 1 on idx 3", upd_cnt);
    end
    n_checks++;
    if (dp !== EXP_DP_FINAL) begin n_fail++; $display("FAIL dp_value: got %b expected %b", dp, EXP_DP_FINAL); end
    n_checks++;
    if (digit_bcd !== 16'h0FF1 || digit_valid !== 4'b1001) begin
      n_fail++; $display("FAIL final_regs: got %h %b expected 0ff1 1001", digit_bcd, digit_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_counts();
    test_reset();
    test_first_capture();
    test_scan();
    test_glitch();
    test_err_blank();
    test_unselectable_and_reset();
    test_dp();
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL update_err_overlap: got %0d expected 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side monitor for the team's multiplexed, active-low seven-segment display bus. It samples the segment lines (dp,g,f,e,d,c,b,a) and the per-digit anode enables. When the pattern for a single selected digit has been stable, it decodes the pattern back to a BCD value and stores it in a per-digit register. It sits beside the display driver, either in self-checking benches or in on-chip readback, and closes the loop from BCD to segments and back to BCD.

## Interface
Parameters:
- DIGITS, default 4: number of multiplexed digits (anode lines); 1..8.
- STABLE_CYCLES, default 4: consecutive identical samples required before a capture; 1..255.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg  in  8  segment lines, active-low; bit7 = dp, bits6:0 = g..a.
- an  in  DIGITS  anode enables, active-low; exactly one low selects that digit.
- digit_bcd  out  4*DIGITS  decoded value per digit; digit i occupies bits 4i+3:4i; 4'hF = blank or unknown.
- digit_valid  out  DIGITS  1 = digit i holds a decoded 0..9.
- dp  out  DIGITS  captured decimal point per digit, 1 = lit.
- update  out  1  one-cycle pulse when any digit register is written.
- update_idx  out  3  index of the digit written on the update pulse.
- err  out  1  one-cycle pulse on a stable but unrecognised pattern.

## Operation
- Input register: seg and an are registered once each cycle and form sample S.
- Compare register: the previous sample P is held. The compare covers an and seg[6:0], plus seg[7] when the dp feature is built in.
- Select rule: S is selectable only when exactly one bit of an is 0. Zero or multiple low bits are not selectable.
- State machine:
  - IDLE to SETTLE when S is selectable; the counter loads 1.
  - SETTLE: if S equals P, the counter increments. When the counter reaches STABLE_CYCLES, the block performs a capture and moves to CAPTURED.
  - SETTLE: if S differs from P and is still selectable, the counter reloads 1 and the state stays SETTLE.
  - SETTLE or CAPTURED to IDLE, counter cleared, when S is not selectable.
  - CAPTURED holds with no further capture until S differs from P. It then goes to SETTLE with the counter at 1.
- Capture decode on seg[6:0]:
  - Digit patterns: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - Decoded digit: digit_bcd[i] is written with the value, digit_valid[i]=1, update=1, update_idx=i.
  - Blank pattern 0x7F: digit_bcd[i]=4'hF, digit_valid[i]=0, update=1.
  - Any other pattern: err=1. digit i is unchanged and update stays 0.
- dp[i] is written with ~seg[7] on every capture that raises update. It is not written on err.
- update and err are never high in the same cycle.
- Counter width is $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - digit_bcd = all 4'hF; digit_valid = 0; dp = 0.
  - update = 0; update_idx = 0; err = 0.
  - state = IDLE; counter = 0; input and compare registers = all ones.
- Latency: a clean pattern presented before edge 0 and held produces update/err registered on edge STABLE_CYCLES. The digit registers change on the same edge.
- A change on seg or an during SETTLE restarts the count. A glitch shorter than STABLE_CYCLES samples never captures.
- Reset assertion mid-settle or mid-capture clears everything asynchronously. The first capture after release needs a full STABLE_CYCLES window.
- Inputs are assumed synchronous to clk. Synchronisers, if needed, sit upstream.

## Configuration
- SEG_SCAN_DP_EN defined: seg[7] takes part in the stability compare and dp[i] is captured as described.
- SEG_SCAN_DP_EN undefined: seg[7] is ignored everywhere, and dp is tied to all zeros.

## Test plan
- Reset, then hold an=4'b1110, seg=0xC0 for 10 cycles. Expect one update on edge 4 with update_idx=0, digit_bcd[3:0]=0, digit_valid[0]=1, and no second update.
- Scan digits 0..3 with patterns 0xA4, 0x99, 0x82, 0x90, 6 cycles each. Expect digit_bcd=16'h9642, digit_valid=4'hF, and four updates with idx 0,1,2,3.
- On digit 2, hold 0xB0 for 3 cycles, then 0x80 for 5 cycles. Expect no capture of 3; a single capture of 8 on the 4th stable edge.
- On digit 1, present 0x8C for 6 cycles. Expect one err pulse, no update, and digit 1 unchanged. Then present 0xFF: expect update with digit_valid[1]=0 and digit_bcd[7:4]=4'hF.
- Present an=4'b1100 or 4'b1111 for 8 cycles. Expect no update and no err. Then assert rst_n=0 for 1 cycle mid-SETTLE and expect all outputs at reset values.
- With SEG_SCAN_DP_EN defined, present seg=0x40 on digit 3 and expect dp[3]=1 with value 0. With it undefined, expect dp=0.
